// File: rtl/data_mem_responder.sv
// data_mem_responder: slave end of the rv32i load/store port. Accepts one
// request at a time, commits byte-masked stores into a word array on the
// acceptance edge, and returns full load words with a one-cycle data_valid
// pulse a fixed number of cycles after acceptance.
module data_mem_responder #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned Latency   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 request,
    input  logic                 we_re,
    input  logic [3:0]           mask,
    input  logic [DataWidth-1:0] address,
    input  logic [DataWidth-1:0] store_data,
    output logic                 ready,
    output logic                 data_valid,
    output logic [DataWidth-1:0] load_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] LoadCnt = (Latency > 1) ? 4'(Latency - 2) : 4'd0;

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_next;
    logic                   r_we;
    logic [AddrWidth-1:0]   r_idx;
    logic [DataWidth-1:0]   r_mem [2**AddrWidth];

    logic                   w_accept;
    logic [AddrWidth-1:0]   w_idx;
    logic [AddrWidth-1:0]   w_rd_idx;
    logic                   w_rd_en;
    logic                   w_unused;

    // Byte offset and bits above the array depth are ignored, so addresses alias.
    assign w_idx    = address[AddrWidth+1:2];
    assign w_unused = ^{address[1:0], address[DataWidth-1:AddrWidth+2]};
    assign w_accept = request && ready;

    // With Latency=1 the RESP entry edge is the acceptance edge itself, so the
    // read must use the live request fields instead of the captured ones.
    assign w_rd_idx = (r_state == S_WAIT) ? r_idx : w_idx;
    assign w_rd_en  = (r_state == S_WAIT) ? ((r_cnt == 4'd0) && !r_we)
                                          : (w_accept && (Latency == 1) && !we_re);

    // State register, latency counter, captured request and load word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_idx     <= '0;
            load_data <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we  <= we_re;
                r_idx <= w_idx;
            end
            if (w_rd_en) begin
                load_data <= r_mem[w_rd_idx];
            end
        end
    end

    // Store commit on the acceptance edge; the array is never reset.
    always_ff @(posedge clk) begin
        if (rst && w_accept && we_re) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_accept) begin
                    if (Latency == 1) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = LoadCnt;
                    end
                end else if (r_state == S_RESP) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready      = (r_state != S_WAIT);
        data_valid = (r_state == S_RESP);
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at Latency 1, 2 and 3.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        we_re;
    logic [3:0]  mask;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        req1, req2, req3;
    logic        rdy1, rdy2, rdy3;
    logic        dv1, dv2, dv3;
    logic [31:0] ld1, ld2, ld3;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [31:0] v1 [4];

    data_mem_responder #(.DataWidth(32), .AddrWidth(10), .Latency(1)) u_l1 (
        .clk(clk), .rst(rst), .request(req1), .we_re(we_re), .mask(mask),
        .address(address), .store_data(store_data),
        .ready(rdy1), .data_valid(dv1), .load_data(ld1)
    );

    data_mem_responder #(.DataWidth(32), .AddrWidth(10), .Latency(2)) u_l2 (
        .clk(clk), .rst(rst), .request(req2), .we_re(we_re), .mask(mask),
        .address(address), .store_data(store_data),
        .ready(rdy2), .data_valid(dv2), .load_data(ld2)
    );

    data_mem_responder #(.DataWidth(32), .AddrWidth(10), .Latency(3)) u_l3 (
        .clk(clk), .rst(rst), .request(req3), .we_re(we_re), .mask(mask),
        .address(address), .store_data(store_data),
        .ready(rdy3), .data_valid(dv3), .load_data(ld3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] get_dv(input int unsigned lat);
        case (lat)
            1:       return 32'(dv1);
            2:       return 32'(dv2);
            default: return 32'(dv3);
        endcase
    endfunction

    function automatic logic [31:0] get_rdy(input int unsigned lat);
        case (lat)
            1:       return 32'(rdy1);
            2:       return 32'(rdy2);
            default: return 32'(rdy3);
        endcase
    endfunction

    function automatic logic [31:0] get_ld(input int unsigned lat);
        case (lat)
            1:       return ld1;
            2:       return ld2;
            default: return ld3;
        endcase
    endfunction

    task automatic set_req(input int unsigned lat, input logic v);
        case (lat)
            1:       req1 = v;
            2:       req2 = v;
            default: req3 = v;
        endcase
    endtask

    // One transaction on the selected instance with cycle-exact pulse checks.
    task automatic txn(input int unsigned lat, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m,
                       input logic [31:0] exp_ld, input string tag);
        @(negedge clk);
        we_re = we; address = a; store_data = d; mask = m;
        set_req(lat, 1'b1);
        for (int unsigned c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c == 1) set_req(lat, 1'b0);
            check_eq({tag, "_dv"}, get_dv(lat), (c == lat) ? 32'd1 : 32'd0);
            if (c <= lat) check_eq({tag, "_rdy"}, get_rdy(lat), (c == lat) ? 32'd1 : 32'd0);
            if (c == lat) check_eq({tag, "_ld"}, get_ld(lat), exp_ld);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; we_re = 1'b0; mask = 4'h0; address = '0; store_data = '0;
        req1 = 1'b0; req2 = 1'b0; req3 = 1'b0;
        v1[0] = 32'hA5A5_0001; v1[1] = 32'h1234_5678; v1[2] = 32'h0F0F_F0F0; v1[3] = 32'hFEDC_BA98;

        repeat (2) @(negedge clk);
        check_eq("rst_rdy2", 32'(rdy2), 32'd1);
        check_eq("rst_dv2",  32'(dv2),  32'd0);
        check_eq("rst_ld2",  ld2,       32'h0);
        check_eq("rst_ld1",  ld1,       32'h0);
        check_eq("rst_ld3",  ld3,       32'h0);
        rst = 1'b1;

        // Latency 2: full word, byte lanes, empty mask, aliasing
        txn(2, 1'b1, 32'h10,   32'h0102_0304, 4'hF, 32'h0,          "st10");
        txn(2, 1'b0, 32'h10,   32'h0,         4'h0, 32'h0102_0304,  "ld10");
        txn(2, 1'b1, 32'h40,   32'hDEAD_BEEF, 4'hF, 32'h0102_0304,  "st40");
        txn(2, 1'b0, 32'h40,   32'h0,         4'h0, 32'hDEAD_BEEF,  "ld40");
        txn(2, 1'b1, 32'h80,   32'h1122_3344, 4'hF, 32'hDEAD_BEEF,  "st80");
        txn(2, 1'b1, 32'h80,   32'h0000_AA00, 4'h2, 32'hDEAD_BEEF,  "st80b1");
        txn(2, 1'b0, 32'h80,   32'h0,         4'h0, 32'h1122_AA44,  "ld80a");
        txn(2, 1'b1, 32'h80,   32'hFFFF_FFFF, 4'h0, 32'h1122_AA44,  "st80m0");
        txn(2, 1'b0, 32'h80,   32'h0,         4'h0, 32'h1122_AA44,  "ld80b");
        txn(2, 1'b1, 32'h1004, 32'h5A5A_5A5A, 4'hF, 32'h1122_AA44,  "st1004");
        txn(2, 1'b0, 32'h0004, 32'h0,         4'h0, 32'h5A5A_5A5A,  "ld0004");
        txn(2, 1'b0, 32'h0006, 32'h0,         4'h0, 32'h5A5A_5A5A,  "ld0006");

        // Reset right after a load is accepted: no pulse, back to idle
        @(negedge clk);
        we_re = 1'b0; address = 32'h40; mask = 4'h0; req2 = 1'b1;
        @(negedge clk);
        req2 = 1'b0; rst = 1'b0;
        @(negedge clk);
        check_eq("rstmid_dv",  32'(dv2),  32'd0);
        check_eq("rstmid_rdy", 32'(rdy2), 32'd1);
        check_eq("rstmid_ld",  ld2,       32'h0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstmid_dv_after", 32'(dv2), 32'd0);

        // Store survives a reset that aborts its response
        @(negedge clk);
        we_re = 1'b1; address = 32'h200; store_data = 32'hCAFE_F00D; mask = 4'hF; req2 = 1'b1;
        @(negedge clk);
        req2 = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_eq("rstst_dv", 32'(dv2), 32'd0);
        txn(2, 1'b0, 32'h200, 32'h0, 4'h0, 32'hCAFE_F00D, "ld200");

        // Latency 1: preload, then four back-to-back loads
        for (int unsigned i = 0; i < 4; i++)
            txn(1, 1'b1, 32'(i * 4), v1[i], 4'hF, 32'h0, "l1_st");
        @(negedge clk);
        we_re = 1'b0; mask = 4'h0; address = 32'h0; req1 = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("l1_b2b_dv", 32'(dv1), 32'd1);
            check_eq("l1_b2b_ld", ld1, v1[i]);
            if (i < 3) address = 32'((i + 1) * 4);
            else       req1 = 1'b0;
        end
        @(negedge clk);
        check_eq("l1_b2b_end", 32'(dv1), 32'd0);

        // Latency 3: held request, junk stores driven while not ready
        txn(3, 1'b1, 32'h20, 32'h600D_F00D, 4'hF, 32'h0, "l3_st");
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j > 0) begin
                check_eq("l3_hold_dv",  32'(dv3),  (j % 3 == 0) ? 32'd1 : 32'd0);
                check_eq("l3_hold_rdy", 32'(rdy3), (j % 3 == 0) ? 32'd1 : 32'd0);
                if (j % 3 == 0) check_eq("l3_hold_ld", ld3, 32'h600D_F00D);
            end
            if (j == 9) begin
                req3 = 1'b0;
            end else begin
                req3 = 1'b1;
                address = 32'h20;
                if (j % 3 == 0) begin
                    we_re = 1'b0; mask = 4'h0;
                end else begin
                    we_re = 1'b1; mask = 4'hF; store_data = 32'hBAD0_BAD0;
                end
            end
        end
        @(negedge clk);
        check_eq("l3_hold_end", 32'(dv3), 32'd0);
        txn(3, 1'b0, 32'h20, 32'h0, 4'h0, 32'h600D_F00D, "l3_ld");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
